image_frame_capture: RTL and testbench

Single-frame capture stage directly downstream of the MIPI CSI-2 PHY wrapper. Consumes the PHY's 4-pixel RAW10 beats and sync strobes. On an arm request it captures exactly one frame, starting at SOF. It tags each beat with start-of-frame and end-of-line flags and buffers it in a small FIFO, so the non-backpressurable PHY stream becomes a valid/ready stream. Frame geometry and errors are checked and reported to the host-facing logic.

---
 rtl/image_frame_capture.sv | 245 ++++++++++++++++++++++++
 tb/tb_image_frame_capture.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/image_frame_capture.sv
// -----------------------------------------------------------------------------
// image_frame_capture
//   Captures exactly one RAW10 frame (4 pixels per beat) from the CSI-2 PHY
//   wrapper after an arm request. Each beat is tagged with SOF/EOL flags and
//   buffered in a first-word-fall-through FIFO, which turns the
//   non-backpressurable PHY stream into a valid/ready stream. Frame geometry
//   and PHY errors are checked and reported as pulses plus a latched code.
//
//   Optional feature macro: IMAGE_CAPTURE_GEOMETRY_CHECK_EN
//     defined   -> beat-per-line (code 4) and line-per-frame (code 5) checks
//     undefined -> no geometry aborts; counters are still maintained
//
// Ports
//   i_video_aclk     clock, all logic on the rising edge
//   i_reset          synchronous, active-high reset
//   i_capture_arm    one-cycle request to capture the next frame
//   i_pix_data[39:0] four 10-bit pixels, pixel 0 in [9:0]
//   i_line_valid     beat valid
//   i_sync_sof       first beat of frame (qualified by i_line_valid)
//   i_sync_eol       last beat of line (qualified by i_line_valid)
//   i_sync_eof       end-of-frame pulse, not beat aligned
//   i_sync_error     PHY SoT sync error pulse
//   o_out_data       buffered beat, o_out_sof/o_out_eol carried with it
//   o_out_valid      head of FIFO valid; i_out_ready accepts it
//   o_busy           FSM not idle
//   o_frame_done     one-cycle pulse, clean frame
//   o_frame_error    one-cycle pulse, capture aborted
//   o_error_code     cause of the last abort (1 overflow, 2 sync error,
//                    3 unexpected SOF, 4 beat count, 5 line count)
//   o_frame_count    clean frames captured, wraps
// -----------------------------------------------------------------------------
module image_frame_capture #(
    parameter int H_BEATS = 480,
    parameter int V_LINES = 1080,
    parameter int FIFO_AW = 4
) (
    input  logic        i_video_aclk,
    input  logic        i_reset,
    input  logic        i_capture_arm,
    input  logic [39:0] i_pix_data,
    input  logic        i_line_valid,
    input  logic        i_sync_sof,
    input  logic        i_sync_eol,
    input  logic        i_sync_eof,
    input  logic        i_sync_error,
    output logic [39:0] o_out_data,
    output logic        o_out_sof,
    output logic        o_out_eol,
    output logic        o_out_valid,
    input  logic        i_out_ready,
    output logic        o_busy,
    output logic        o_frame_done,
    output logic        o_frame_error,
    output logic [2:0]  o_error_code,
    output logic [15:0] o_frame_count
);

`ifdef IMAGE_CAPTURE_GEOMETRY_CHECK_EN
    localparam bit GEO_EN = 1'b1;
`else
    localparam bit GEO_EN = 1'b0;
`endif

    localparam int DEPTH = 1 << FIFO_AW;

    typedef enum logic [1:0] {S_IDLE, S_WAIT_SOF, S_ACTIVE, S_DISCARD} state_t;

    function automatic logic [11:0] sat_inc(input logic [11:0] v);
        return (v == 12'hFFF) ? v : v + 12'd1;
    endfunction

    // ---------------- input stage ----------------
    logic        r_arm, r_lv, r_sof, r_eol, r_eof, r_serr;
    logic [39:0] r_data;

    always_ff @(posedge i_video_aclk) begin
        if (i_reset) begin
            r_arm  <= 1'b0;
            r_lv   <= 1'b0;
            r_sof  <= 1'b0;
            r_eol  <= 1'b0;
            r_eof  <= 1'b0;
            r_serr <= 1'b0;
            r_data <= '0;
        end else begin
            r_arm  <= i_capture_arm;
            r_lv   <= i_line_valid;
            r_sof  <= i_sync_sof;
            r_eol  <= i_sync_eol;
            r_eof  <= i_sync_eof;
            r_serr <= i_sync_error;
            r_data <= i_pix_data;
        end
    end

    // ---------------- FIFO (FWFT) ----------------
    logic [41:0]        r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [FIFO_AW:0]   r_count;
    logic               w_full, w_empty, w_push, w_pop;

    assign w_full  = (r_count == (FIFO_AW+1)'(DEPTH));
    assign w_empty = (r_count == '0);
    // i_out_ready is the consumer handshake, so it acts directly on the
    // FIFO head rather than through the input stage.
    assign w_pop   = !w_empty && i_out_ready;

    always_ff @(posedge i_video_aclk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_video_aclk) begin
        if (w_push) r_mem[r_wr_ptr] <= {r_sof, r_eol, r_data};
    end

    assign o_out_valid = !w_empty;
    assign o_out_data  = w_empty ? 40'd0 : r_mem[r_rd_ptr][39:0];
    assign o_out_sof   = w_empty ? 1'b0  : r_mem[r_rd_ptr][41];
    assign o_out_eol   = w_empty ? 1'b0  : r_mem[r_rd_ptr][40];

    // ---------------- capture FSM ----------------
    state_t      r_state, w_state_nxt;
    logic [11:0] r_beat_cnt, r_line_cnt, w_beat_nxt, w_line_nxt;
    logic [11:0] w_beat_inc, w_line_eff;
    logic        w_beat_bad, w_line_bad;
    logic        w_done, w_err;
    logic [2:0]  w_cause, w_code_nxt;
    logic [15:0] w_fc_nxt;
    logic        r_frame_done, r_frame_error;
    logic [2:0]  r_error_code;
    logic [15:0] r_frame_count;

    assign w_beat_inc = sat_inc(r_beat_cnt);
    // Line count as it stands once this cycle's eol (if any) is taken into
    // account, so an eol beat coinciding with eof is counted.
    assign w_line_eff = (r_lv && r_eol) ? sat_inc(r_line_cnt) : r_line_cnt;
    // A saturated counter can never legitimately match.
    assign w_beat_bad = GEO_EN && r_lv && r_eol &&
                        (w_beat_inc != 12'(H_BEATS) || w_beat_inc == 12'hFFF);
    assign w_line_bad = GEO_EN && r_eof &&
                        (w_line_eff != 12'(V_LINES) || w_line_eff == 12'hFFF);

    always_ff @(posedge i_video_aclk) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_beat_nxt  = r_beat_cnt;
        w_line_nxt  = r_line_cnt;
        w_done      = 1'b0;
        w_err       = 1'b0;
        w_cause     = 3'd0;
        w_code_nxt  = r_error_code;
        case (r_state)
            S_IDLE: begin
                if (r_arm) begin
                    w_state_nxt = S_WAIT_SOF;
                    w_code_nxt  = 3'd0;
                end
            end
            S_WAIT_SOF: begin
                if (r_lv && r_sof) begin
                    w_state_nxt = S_ACTIVE;
                    w_push      = !w_full;
                    w_beat_nxt  = r_eol ? 12'd0 : 12'd1;
                    w_line_nxt  = r_eol ? 12'd1 : 12'd0;
                end
            end
            S_ACTIVE: begin
                if (r_lv && w_full)     w_cause = 3'd1;
                else if (r_serr)        w_cause = 3'd2;
                else if (r_lv && r_sof) w_cause = 3'd3;
                else if (w_beat_bad)    w_cause = 3'd4;
                else if (w_line_bad)    w_cause = 3'd5;

                if (w_cause != 3'd0) begin
                    // Faulting beat is dropped; an abort on the eof cycle
                    // has nothing left to discard.
                    w_err       = 1'b1;
                    w_code_nxt  = w_cause;
                    w_state_nxt = r_eof ? S_IDLE : S_DISCARD;
                end else begin
                    if (r_lv) begin
                        w_push = 1'b1;
                        if (r_eol) begin
                            w_beat_nxt = 12'd0;
                            w_line_nxt = w_line_eff;
                        end else begin
                            w_beat_nxt = w_beat_inc;
                        end
                    end
                    if (r_eof) begin
                        w_done      = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_DISCARD: begin
                if (r_eof) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        w_fc_nxt = w_done ? r_frame_count + 16'd1 : r_frame_count;
    end

    always_ff @(posedge i_video_aclk) begin
        if (i_reset) begin
            r_beat_cnt    <= '0;
            r_line_cnt    <= '0;
            r_frame_done  <= 1'b0;
            r_frame_error <= 1'b0;
            r_error_code  <= '0;
            r_frame_count <= '0;
        end else begin
            r_beat_cnt    <= w_beat_nxt;
            r_line_cnt    <= w_line_nxt;
            r_frame_done  <= w_done;
            r_frame_error <= w_err;
            r_error_code  <= w_code_nxt;
            r_frame_count <= w_fc_nxt;
        end
    end

    assign o_busy        = (r_state != S_IDLE);
    assign o_frame_done  = r_frame_done;
    assign o_frame_error = r_frame_error;
    assign o_error_code  = r_error_code;
    assign o_frame_count = r_frame_count;

endmodule

// File: tb/tb_image_frame_capture.sv
// Directed bench for image_frame_capture with H_BEATS=4, V_LINES=3, FIFO_AW=2.
module tb_image_frame_capture;

    logic        clk = 1'b0;
    logic        reset, capture_arm, line_valid, sync_sof, sync_eol, sync_eof, sync_error;
    logic [39:0] pix_data;
    logic [39:0] out_data;
    logic        out_sof, out_eol, out_valid, out_ready;
    logic        busy, frame_done, frame_error;
    logic [2:0]  error_code;
    logic [15:0] frame_count;

    int n_chk = 0;
    int n_fail = 0;
    int n_done = 0;
    int n_err = 0;
    logic [41:0] q[$];
    logic [15:0] exp_fc;

    image_frame_capture #(.H_BEATS(4), .V_LINES(3), .FIFO_AW(2)) dut (
        .i_video_aclk (clk),
        .i_reset      (reset),
        .i_capture_arm(capture_arm),
        .i_pix_data   (pix_data),
        .i_line_valid (line_valid),
        .i_sync_sof   (sync_sof),
        .i_sync_eol   (sync_eol),
        .i_sync_eof   (sync_eof),
        .i_sync_error (sync_error),
        .o_out_data   (out_data),
        .o_out_sof    (out_sof),
        .o_out_eol    (out_eol),
        .o_out_valid  (out_valid),
        .i_out_ready  (out_ready),
        .o_busy       (busy),
        .o_frame_done (frame_done),
        .o_frame_error(frame_error),
        .o_error_code (error_code),
        .o_frame_count(frame_count)
    );

    always #5 clk = ~clk;

    // Record accepted beats and status pulses half a cycle away from the edge.
    always @(negedge clk) begin
        if (out_valid && out_ready) q.push_back({out_sof, out_eol, out_data});
        if (frame_done)  n_done++;
        if (frame_error) n_err++;
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [39:0] pd(input int k);
        return {10'(k + 3), 10'(k + 2), 10'(k + 1), 10'(k)};
    endfunction

    // Hold one cycle of input, then return to idle 1 time unit after the edge.
    task automatic cyc(input logic lv, sof, eol, eof, serr, arm, input logic [39:0] d);
        line_valid = lv; sync_sof = sof; sync_eol = eol; sync_eof = eof;
        sync_error = serr; capture_arm = arm; pix_data = d;
        @(posedge clk); #1;
        line_valid = 0; sync_sof = 0; sync_eol = 0; sync_eof = 0;
        sync_error = 0; capture_arm = 0; pix_data = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(0, 0, 0, 0, 0, 0, '0);
    endtask

    task automatic beat(input logic sof, eol, input int k);
        cyc(1, sof, eol, 0, 0, 0, pd(k));
    endtask

    task automatic arm();
        cyc(0, 0, 0, 0, 0, 1, '0);
        idle(1);
    endtask

    task automatic eof();
        cyc(0, 0, 0, 1, 0, 0, '0);
    endtask

    task automatic clear_mon();
        q.delete(); n_done = 0; n_err = 0;
    endtask

    // 3 lines x 4 beats, beat k carries pd(base + 4*line + beat).
    task automatic clean_frame(input int base);
        for (int l = 0; l < 3; l++)
            for (int b = 0; b < 4; b++)
                beat(l == 0 && b == 0, b == 3, base + l * 4 + b);
        eof();
        idle(4);
    endtask

    initial begin
        reset = 1; out_ready = 1;
        line_valid = 0; sync_sof = 0; sync_eol = 0; sync_eof = 0;
        sync_error = 0; capture_arm = 0; pix_data = '0;
        exp_fc = 0;
        repeat (3) @(posedge clk);
        #1 reset = 0;

        // ---- reset state ----
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_code", error_code, 0);
        chk("rst_fc", frame_count, 0);

        // ---- clean frame, latency and pulse timing ----
        clear_mon();
        cyc(0, 0, 0, 0, 0, 1, '0);
        chk("busy_arm0", busy, 0);
        idle(1);
        chk("busy_arm1", busy, 1);
        for (int l = 0; l < 3; l++)
            for (int b = 0; b < 4; b++) begin
                beat(l == 0 && b == 0, b == 3, l * 4 + b);
                if (l == 0 && b == 0) chk("lat_n1", out_valid, 0);
                if (l == 0 && b == 1) begin
                    chk("lat_n2_valid", out_valid, 1);
                    chk("lat_n2_sof", out_sof, 1);
                    chk("lat_n2_data", out_data, pd(0));
                end
            end
        eof();
        chk("done_n1", frame_done, 0);
        idle(1);
        chk("done_n2", frame_done, 1);
        chk("busy_done", busy, 0);
        idle(1);
        chk("done_pulse", frame_done, 0);
        idle(2);
        exp_fc++;
        chk("c1_ndone", n_done, 1);
        chk("c1_nerr", n_err, 0);
        chk("c1_beats", q.size(), 12);
        for (int i = 0; i < 12 && i < q.size(); i++)
            chk($sformatf("c1_beat%0d", i), q[i], {i == 0, (i % 4) == 3, pd(i)});
        chk("c1_fc", frame_count, exp_fc);
        chk("c1_code", error_code, 0);

        // ---- 5 beats on line 1 ----
        clear_mon();
        arm();
        for (int b = 0; b < 4; b++) beat(b == 0, b == 3, 50 + b);
        for (int b = 0; b < 5; b++) beat(0, b == 4, 60 + b);
        for (int b = 0; b < 4; b++) beat(0, b == 3, 70 + b);
        chk("geo_busy_pre", busy, 1);
        eof();
        idle(4);
        chk("geo_busy_post", busy, 0);
`ifdef IMAGE_CAPTURE_GEOMETRY_CHECK_EN
        chk("geo_nerr", n_err, 1);
        chk("geo_ndone", n_done, 0);
        chk("geo_code", error_code, 4);
        chk("geo_beats", q.size(), 8);
`else
        exp_fc++;
        chk("geo_nerr", n_err, 0);
        chk("geo_ndone", n_done, 1);
        chk("geo_code", error_code, 0);
        chk("geo_beats", q.size(), 13);
`endif
        chk("geo_fc", frame_count, exp_fc);

        // ---- overflow with consumer stalled ----
        clear_mon();
        out_ready = 0;
        arm();
        for (int b = 0; b < 6; b++) beat(b == 0, 0, 100 + b);
        idle(2);
        chk("ovf_nerr", n_err, 1);
        chk("ovf_code", error_code, 1);
        chk("ovf_busy", busy, 1);
        chk("ovf_head", out_data, pd(100));
        eof();
        idle(2);
        chk("ovf_busy_eof", busy, 0);
        out_ready = 1;
        idle(8);
        chk("ovf_drain", q.size(), 4);
        for (int i = 0; i < 4 && i < q.size(); i++)
            chk($sformatf("ovf_d%0d", i), q[i], {i == 0, 1'b0, pd(100 + i)});
        chk("ovf_empty", out_valid, 0);

        // ---- sync_error while active ----
        clear_mon();
        arm();
        beat(1, 0, 300);
        beat(0, 0, 301);
        cyc(1, 0, 0, 0, 1, 0, pd(302));
        chk("serr_n1", frame_error, 0);
        idle(1);
        chk("serr_pulse", frame_error, 1);
        chk("serr_code", error_code, 2);
        eof();
        idle(3);
        chk("serr_beats", q.size(), 2);
        chk("serr_busy", busy, 0);

        // ---- sync_error in WAIT_SOF is ignored ----
        clear_mon();
        arm();
        chk("ws_code_clr", error_code, 0);
        cyc(0, 0, 0, 0, 1, 0, '0);
        idle(2);
        chk("ws_busy", busy, 1);
        chk("ws_nerr", n_err, 0);
        clean_frame(400);
        exp_fc++;
        chk("ws_ndone", n_done, 1);
        chk("ws_beats", q.size(), 12);
        chk("ws_fc", frame_count, exp_fc);

        // ---- pre-SOF beats dropped, second SOF aborts ----
        clear_mon();
        arm();
        beat(0, 0, 200);
        beat(0, 0, 204);
        beat(1, 0, 208);
        beat(0, 0, 212);
        beat(1, 0, 216);
        idle(1);
        chk("sof2_pulse", frame_error, 1);
        chk("sof2_code", error_code, 3);
        eof();
        idle(3);
        chk("sof2_beats", q.size(), 2);
        if (q.size() >= 2) begin
            chk("sof2_q0", q[0], {1'b1, 1'b0, pd(208)});
            chk("sof2_q1", q[1], {1'b0, 1'b0, pd(212)});
        end

        // ---- reset mid-line ----
        clear_mon();
        out_ready = 0;
        arm();
        beat(1, 0, 500);
        beat(0, 0, 501);
        reset = 1;
        cyc(1, 0, 0, 0, 0, 0, pd(502));
        reset = 0;
        chk("mrst_valid", out_valid, 0);
        chk("mrst_data", out_data, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_code", error_code, 0);
        chk("mrst_fc", frame_count, 0);
        out_ready = 1;
        idle(3);
        chk("mrst_pulses", n_done + n_err, 0);
        chk("mrst_beats", q.size(), 0);
        exp_fc = 0;
        arm();
        clean_frame(600);
        exp_fc++;
        chk("mrst_ndone", n_done, 1);
        chk("mrst_fc", frame_count, exp_fc);

        // ---- frame_count wrap ----
        force dut.r_frame_count = 16'hFFFF;
        @(posedge clk); #1;
        release dut.r_frame_count;
        idle(1);
        arm();
        clean_frame(700);
        chk("wrap_fc", frame_count, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_fail);
        $finish;
    end

endmodule
